// File: rtl/riscv_pkg.sv
// Shared RV32 fetch types: NOP encoding, fetch FSM states and the IF/ID payload.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DISCARD} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP, pc: '0, pc4: '0};
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_stage_if;
  import riscv_pkg::*;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_hold_buf.sv
// Parks one fetched word while decode is stalled or flushed.
module fetch_hold_buf
  import riscv_pkg::*;
(
  input  logic  clk,
  input  logic  srst,
  input  logic  wr,
  input  logic  clr,
  input  ifid_t wr_data,
  output ifid_t data,
  output logic  valid
);
  always_ff @(posedge clk) begin
    if (srst || clr) valid <= 1'b0;
    else if (wr)     valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr) data <= wr_data;
  end
endmodule

// File: rtl/fetch_stage.sv
// IF stage: one outstanding imem request, IF/ID register, redirect handling.
// Optional FETCH_MISALIGN_CHK_EN adds a sticky misaligned-redirect flag.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            misalign_err
);
  fetch_state_e    state, state_nx;
  logic [XLEN-1:0] pc_f, pc_nx, pc_f4;
  ifid_t           ifid, ifid_nx, fetched, hb_data;
  logic            hb_wr, hb_clr, hb_valid;

  assign pc_f4          = pc_f + XLEN'(4);
  assign fetched        = '{instr: imem.imem_rdata, pc: pc_f, pc4: pc_f4};
  assign imem.imem_req  = (state == ISSUE) & ~srst & ~pc_src_e;
  assign imem.imem_addr = pc_f;

  assign instr_d    = ifid.instr;
  assign pc_d       = ifid.pc;
  assign pc_plus4_d = ifid.pc4;

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .srst    (srst),
    .wr      (hb_wr),
    .clr     (hb_clr),
    .wr_data (fetched),
    .data    (hb_data),
    .valid   (hb_valid)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= ISSUE;
      pc_f  <= RESET_PC;
      ifid  <= BUBBLE;
    end else begin
      state <= state_nx;
      pc_f  <= pc_nx;
      ifid  <= ifid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_f;
    ifid_nx  = ifid;
    hb_wr    = 1'b0;
    hb_clr   = 1'b0;
    case (state)
      ISSUE: if (!pc_src_e) state_nx = WAIT;
      WAIT: begin
        if (pc_src_e) begin
          state_nx = imem.imem_rvalid ? ISSUE : DISCARD;
        end else if (imem.imem_rvalid) begin
          pc_nx = pc_f4;
          if (stall_d || flush_d) begin
            hb_wr    = 1'b1;
            state_nx = HOLD;
          end else begin
            ifid_nx  = fetched;
            state_nx = ISSUE;
          end
        end
      end
      HOLD: begin
        if (pc_src_e) begin
          state_nx = ISSUE;
        end else if (!stall_d && !flush_d) begin
          ifid_nx  = hb_valid ? hb_data : BUBBLE;
          hb_clr   = 1'b1;
          state_nx = ISSUE;
        end
      end
      // The stale response is still in flight; a new redirect only retargets
      // pc_f, leaving is gated purely on that response arriving.
      DISCARD: if (imem.imem_rvalid) state_nx = ISSUE;
      default: state_nx = ISSUE;
    endcase

    if (pc_src_e) begin
      pc_nx  = pc_target_e & {{(XLEN-2){1'b1}}, 2'b00};
      hb_clr = 1'b1;
    end
    if (pc_src_e || flush_d) ifid_nx = BUBBLE;
    else if (stall_d)        ifid_nx = ifid;
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (srst) misalign_err <= 1'b0;
    else if (pc_src_e && (pc_target_e[1:0] != 2'b00)) misalign_err <= 1'b1;
  end
`else
  assign misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scripted cycles plus a 1/2-cycle imem model.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0, srst = 1'b1, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [31:0] pc_target_e = '0;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        misalign_err;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk(clk), .srst(srst), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem(imem),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic EXP_MIS = 1'b1;
`else
  localparam logic EXP_MIS = 1'b0;
`endif
  localparam logic [95:0] BUB = {32'h0000_0013, 32'h0, 32'h0};

  int          passed = 0, total = 0, lat = 1;
  logic [95:0] sb[$];
  logic [95:0] last;
  logic [31:0] cur;
  bit          pend = 0;
  logic [31:0] paddr;
  int          age;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'hA5A5_0013);
  endfunction
  function automatic logic [95:0] exp_ent(input logic [31:0] a);
    return {mem_word(a), a, a + 32'd4};
  endfunction

  // imem model: latches a request mid-cycle, answers lat cycles later
  initial begin
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem.imem_req === 1'b1) begin pend = 1; paddr = imem.imem_addr; age = 0; end
      @(posedge clk); #2;
      imem.imem_rvalid = 1'b0;
      if (pend) begin
        age++;
        if (age >= lat) begin
          imem.imem_rvalid = 1'b1;
          imem.imem_rdata  = mem_word(paddr);
          pend = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic nxt; @(posedge clk); #1; endtask
  task automatic mid; @(negedge clk); endtask

  task automatic test_reset;
    srst = 1'b1; nxt; nxt; mid;
    total++; if ({instr_d, pc_d, pc_plus4_d} !== BUB) $display("FAIL reset_ifid got %h want %h", {instr_d, pc_d, pc_plus4_d}, BUB); else passed++;
    total++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign got %b want 0", misalign_err); else passed++;
    total++; if (imem.imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem.imem_req); else passed++;
  endtask

  task automatic test_basic;
    nxt; srst = 1'b0; mid;
    total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h0}) $display("FAIL basic_first_req got %b/%h want 1/0", imem.imem_req, imem.imem_addr); else passed++;
    sb.push_back(exp_ent(32'h0));
    nxt; mid;
    total++; if (imem.imem_req !== 1'b0) $display("FAIL basic_wait_req got %b want 0", imem.imem_req); else passed++;
    nxt; mid;
    last = sb.pop_front();
    total++; if ({instr_d, pc_d, pc_plus4_d} !== last) $display("FAIL basic_ifid got %h want %h", {instr_d, pc_d, pc_plus4_d}, last); else passed++;
    total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h4}) $display("FAIL basic_next_req got %b/%h want 1/4", imem.imem_req, imem.imem_addr); else passed++;
    cur = 32'h4;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(exp_ent(cur));
      nxt; nxt; mid;
      last = sb.pop_front();
      total++; if ({instr_d, pc_d, pc_plus4_d} !== last) $display("FAIL stream_ifid got %h want %h", {instr_d, pc_d, pc_plus4_d}, last); else passed++;
      cur += 32'd4;
      total++; if (imem.imem_addr !== cur) $display("FAIL stream_addr got %h want %h", imem.imem_addr, cur); else passed++;
    end
  endtask

  task automatic test_stall;
    sb.push_back(exp_ent(cur));
    nxt; stall_d = 1'b1; mid;
    for (int i = 0; i < 5; i++) begin
      total++; if ({instr_d, pc_d, pc_plus4_d} !== last) $display("FAIL stall_ifid cyc%0d got %h want %h", i, {instr_d, pc_d, pc_plus4_d}, last); else passed++;
      total++; if (imem.imem_req !== 1'b0) $display("FAIL stall_req cyc%0d got %b want 0", i, imem.imem_req); else passed++;
      nxt; if (i == 3) stall_d = 1'b0; mid;
    end
    last = sb.pop_front();
    total++; if ({instr_d, pc_d, pc_plus4_d} !== last) $display("FAIL stall_release got %h want %h", {instr_d, pc_d, pc_plus4_d}, last); else passed++;
    cur += 32'd4;
    total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, cur}) $display("FAIL stall_next_req got %b/%h want 1/%h", imem.imem_req, imem.imem_addr, cur); else passed++;
  endtask

  task automatic test_flush;
    sb.push_back(exp_ent(cur));
    nxt; flush_d = 1'b1; mid;
    nxt; flush_d = 1'b0; mid;
    total++; if ({instr_d, pc_d, pc_plus4_d} !== BUB) $display("FAIL flush_bubble got %h want %h", {instr_d, pc_d, pc_plus4_d}, BUB); else passed++;
    total++; if (imem.imem_req !== 1'b0) $display("FAIL flush_hold_req got %b want 0", imem.imem_req); else passed++;
    nxt; mid;
    last = sb.pop_front();
    total++; if ({instr_d, pc_d, pc_plus4_d} !== last) $display("FAIL flush_release got %h want %h", {instr_d, pc_d, pc_plus4_d}, last); else passed++;
    cur += 32'd4;
  endtask

  task automatic test_redirect_wait;
    nxt; lat = 2; pc_src_e = 1'b1; pc_target_e = 32'h100; mid;
    total++; if (imem.imem_req !== 1'b0) $display("FAIL rdw_req got %b want 0", imem.imem_req); else passed++;
    nxt; pc_src_e = 1'b0; mid;
    total++; if ({instr_d, pc_d, pc_plus4_d} !== BUB) $display("FAIL rdw_bubble got %h want %h", {instr_d, pc_d, pc_plus4_d}, BUB); else passed++;
    total++; if (imem.imem_req !== 1'b0) $display("FAIL rdw_discard_req got %b want 0", imem.imem_req); else passed++;
    nxt; lat = 1; mid;
    total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h100}) $display("FAIL rdw_target got %b/%h want 1/100", imem.imem_req, imem.imem_addr); else passed++;
    total++; if (instr_d !== NOP) $display("FAIL rdw_dropped got %h want %h", instr_d, NOP); else passed++;
    sb.push_back(exp_ent(32'h100));
    nxt; nxt; mid;
    last = sb.pop_front();
    total++; if ({instr_d, pc_d, pc_plus4_d} !== last) $display("FAIL rdw_ifid got %h want %h", {instr_d, pc_d, pc_plus4_d}, last); else passed++;
    cur = 32'h104;
  endtask

  task automatic test_redirect_rvalid;
    nxt; pc_src_e = 1'b1; pc_target_e = 32'h200; mid;
    nxt; pc_src_e = 1'b0; mid;
    total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h200}) $display("FAIL rdv_target got %b/%h want 1/200", imem.imem_req, imem.imem_addr); else passed++;
    total++; if ({instr_d, pc_d, pc_plus4_d} !== BUB) $display("FAIL rdv_bubble got %h want %h", {instr_d, pc_d, pc_plus4_d}, BUB); else passed++;
    sb.push_back(exp_ent(32'h200));
    nxt; nxt; pc_src_e = 1'b1; pc_target_e = 32'h300; mid;
    last = sb.pop_front();
    total++; if ({instr_d, pc_d, pc_plus4_d} !== last) $display("FAIL rdv_ifid got %h want %h", {instr_d, pc_d, pc_plus4_d}, last); else passed++;
    total++; if (imem.imem_req !== 1'b0) $display("FAIL issue_redirect_req got %b want 0", imem.imem_req); else passed++;
    nxt; pc_src_e = 1'b0; mid;
    total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h300}) $display("FAIL issue_redirect_addr got %b/%h want 1/300", imem.imem_req, imem.imem_addr); else passed++;
    total++; if (instr_d !== NOP) $display("FAIL issue_redirect_bubble got %h want %h", instr_d, NOP); else passed++;
    cur = 32'h300;
  endtask

  task automatic test_wrap;
    nxt; pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC; mid;
    nxt; pc_src_e = 1'b0; mid;
    total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_req got %b/%h want 1/fffffffc", imem.imem_req, imem.imem_addr); else passed++;
    sb.push_back(exp_ent(32'hFFFF_FFFC));
    nxt; nxt; mid;
    last = sb.pop_front();
    total++; if ({instr_d, pc_d, pc_plus4_d} !== last) $display("FAIL wrap_ifid got %h want %h", {instr_d, pc_d, pc_plus4_d}, last); else passed++;
    total++; if (imem.imem_addr !== 32'h0) $display("FAIL wrap_next_addr got %h want 0", imem.imem_addr); else passed++;
    cur = 32'h0;
  endtask

  task automatic test_misalign;
    total++; if (misalign_err !== 1'b0) $display("FAIL mis_pre got %b want 0", misalign_err); else passed++;
    nxt; pc_src_e = 1'b1; pc_target_e = 32'h102; mid;
    nxt; pc_src_e = 1'b0; mid;
    total++; if (misalign_err !== EXP_MIS) $display("FAIL mis_flag got %b want %b", misalign_err, EXP_MIS); else passed++;
    total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h100}) $display("FAIL mis_addr got %b/%h want 1/100", imem.imem_req, imem.imem_addr); else passed++;
    sb.push_back(exp_ent(32'h100));
    nxt; nxt; mid;
    last = sb.pop_front();
    total++; if ({instr_d, pc_d, pc_plus4_d} !== last) $display("FAIL mis_ifid got %h want %h", {instr_d, pc_d, pc_plus4_d}, last); else passed++;
    total++; if (misalign_err !== EXP_MIS) $display("FAIL mis_sticky got %b want %b", misalign_err, EXP_MIS); else passed++;
  endtask

  task automatic test_reset_mid;
    nxt; srst = 1'b1; mid;
    total++; if (imem.imem_req !== 1'b0) $display("FAIL rst_mid_req got %b want 0", imem.imem_req); else passed++;
    nxt; srst = 1'b0; mid;
    total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h0}) $display("FAIL rst_mid_restart got %b/%h want 1/0", imem.imem_req, imem.imem_addr); else passed++;
    total++; if ({instr_d, pc_d, pc_plus4_d} !== BUB) $display("FAIL rst_mid_bubble got %h want %h", {instr_d, pc_d, pc_plus4_d}, BUB); else passed++;
    total++; if (misalign_err !== 1'b0) $display("FAIL rst_mid_misalign got %b want 0", misalign_err); else passed++;
    sb.push_back(exp_ent(32'h0));
    nxt; nxt; mid;
    last = sb.pop_front();
    total++; if ({instr_d, pc_d, pc_plus4_d} !== last) $display("FAIL rst_mid_ifid got %h want %h", {instr_d, pc_d, pc_plus4_d}, last); else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_flush;
    test_redirect_wait;
    test_redirect_rvalid;
    test_wrap;
    test_misalign;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
